// File: rtl/fp16_div_seq.sv
// Sequential FP16 divider, quotient = A / B.
// Restoring division produces one quotient bit per cycle. Flow:
// IDLE -> NORM (subnormal pre-normalisation) -> DIV (14 cycles) -> ROUND -> DONE.
// Zero divisor and zero dividend bypass the datapath and go IDLE -> DONE.
// Results saturate to +/-inf or flush to signed zero. No NaN is ever produced.
module fp16_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] quotient,
  output logic        Overflow,
  output logic        Underflow,
  output logic        DivByZero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StNorm, StDiv, StRound, StDone} state_e;

  localparam int unsigned DivSteps = 14;

  state_e             state_q;
  logic               sign_q;
  logic [10:0]        ma_q, mb_q;
  logic signed [6:0]  ea_q, eb_q, e_q;
  logic [11:0]        r_q;
  logic [13:0]        q_q;
  logic [3:0]         cnt_q;
  logic [15:0]        quotient_q;
  logic               ovf_q, unf_q, dbz_q, busy_q, done_q;

  // Operand decode at acceptance: hidden bit and effective exponent.
  logic               sign_in;
  logic [10:0]        man_a, man_b;
  logic signed [6:0]  eff_a, eff_b;
  logic               a_zero, b_zero;

  // Unpack both operands; a zero exponent means subnormal with effective exponent 1.
  always_comb begin
    sign_in = A[15] ^ B[15];
    man_a   = {(A[14:10] != 5'd0), A[9:0]};
    man_b   = {(B[14:10] != 5'd0), B[9:0]};
    eff_a   = (A[14:10] != 5'd0) ? $signed({2'b00, A[14:10]}) : 7'sd1;
    eff_b   = (B[14:10] != 5'd0) ? $signed({2'b00, B[14:10]}) : 7'sd1;
    a_zero  = (A[14:0] == 15'd0);
    b_zero  = (B[14:0] == 15'd0);
  end

  // One restoring-division step on the current remainder.
  logic        r_ge;
  logic [11:0] r_sub;
  logic [11:0] r_next;

  // Compare, conditionally subtract, then shift the remainder left.
  always_comb begin
    r_ge   = (r_q >= {1'b0, mb_q});
    r_sub  = r_ge ? (r_q - {1'b0, mb_q}) : r_q;
    // r_sub < d < 2^11, so the shifted value always fits in 12 bits.
    r_next = {r_sub[10:0], 1'b0};
  end

  // Rounding datapath (round-to-nearest-even) over the 14 raw quotient bits.
  logic [10:0]       rnd_m;
  logic              rnd_g, rnd_s, rnd_up;
  logic signed [6:0] rnd_e;
  logic [11:0]       rnd_sum;
  logic [9:0]        fin_frac;
  logic signed [6:0] fin_e;

  // Select mantissa/guard/sticky by the quotient's leading bit, round, then renormalise.
  always_comb begin
    if (q_q[13]) begin
      rnd_m = q_q[13:3];
      rnd_g = q_q[2];
      rnd_s = (|q_q[1:0]) | (r_q != 12'd0);
      rnd_e = e_q;
    end else begin
      // Quotient in [0.5, 1): one extra bit is available and the exponent drops by one.
      rnd_m = q_q[12:2];
      rnd_g = q_q[1];
      rnd_s = q_q[0] | (r_q != 12'd0);
      rnd_e = e_q - 7'sd1;
    end
    rnd_up  = rnd_g & (rnd_s | rnd_m[0]);
    rnd_sum = {1'b0, rnd_m} + {11'd0, rnd_up};
    if (rnd_sum[11]) begin
      fin_frac = rnd_sum[10:1];
      fin_e    = rnd_e + 7'sd1;
    end else begin
      fin_frac = rnd_sum[9:0];
      fin_e    = rnd_e;
    end
  end

  // Control FSM with registered datapath state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      ma_q       <= 11'd0;
      mb_q       <= 11'd0;
      ea_q       <= 7'sd0;
      eb_q       <= 7'sd0;
      e_q        <= 7'sd0;
      r_q        <= 12'd0;
      q_q        <= 14'd0;
      cnt_q      <= 4'd0;
      quotient_q <= 16'd0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_q <= sign_in;
            if (b_zero) begin
              // Zero divisor wins over a zero dividend.
              quotient_q <= {sign_in, 5'h1F, 10'h000};
              ovf_q      <= 1'b0;
              unf_q      <= 1'b0;
              dbz_q      <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else if (a_zero) begin
              quotient_q <= {sign_in, 15'd0};
              ovf_q      <= 1'b0;
              unf_q      <= 1'b0;
              dbz_q      <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              ma_q    <= man_a;
              mb_q    <= man_b;
              ea_q    <= eff_a;
              eb_q    <= eff_b;
              busy_q  <= 1'b1;
              state_q <= StNorm;
            end
          end
        end

        StNorm: begin
          if (ma_q[10] && mb_q[10]) begin
            e_q     <= ea_q - eb_q + 7'sd15;
            r_q     <= {1'b0, ma_q};
            q_q     <= 14'd0;
            cnt_q   <= 4'd0;
            state_q <= StDiv;
          end else begin
            if (!ma_q[10]) begin
              ma_q <= {ma_q[9:0], 1'b0};
              ea_q <= ea_q - 7'sd1;
            end
            if (!mb_q[10]) begin
              mb_q <= {mb_q[9:0], 1'b0};
              eb_q <= eb_q - 7'sd1;
            end
          end
        end

        StDiv: begin
          r_q   <= r_next;
          q_q   <= {q_q[12:0], r_ge};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(DivSteps - 1)) begin
            state_q <= StRound;
          end
        end

        StRound: begin
          dbz_q <= 1'b0;
          if (fin_e >= 7'sd31) begin
            quotient_q <= {sign_q, 5'h1F, 10'h000};
            ovf_q      <= 1'b1;
            unf_q      <= 1'b0;
          end else if (fin_e <= 7'sd0) begin
            quotient_q <= {sign_q, 15'd0};
            ovf_q      <= 1'b0;
            unf_q      <= 1'b1;
          end else begin
            quotient_q <= {sign_q, fin_e[4:0], fin_frac};
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end

        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign DivByZero = dbz_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: directed vector table, handshake/reset sequences and
// random operands checked against an exact-ratio rounding model.
module tb_fp16_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [15:0] quotient;
  logic        ovf, unf, dbz, busy, done;

  int errors = 0;
  int checks = 0;

  fp16_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (a),
    .B         (b),
    .quotient  (quotient),
    .Overflow  (ovf),
    .Underflow (unf),
    .DivByZero (dbz),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [2:0]  fl;   // {Overflow, Underflow, DivByZero}
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Count leading zeros of an 11-bit significand (pre-normalisation shift count).
  function automatic int lz11(input longint unsigned m);
    int n = 0;
    while (n < 11 && ((m >> (10 - n)) & 1) == 0) n++;
    return n;
  endfunction

  // Exact rational division, then round-to-nearest-even to 11 significant bits.
  task automatic model(input logic [15:0] ma_in, input logic [15:0] mb_in,
                       output logic [15:0] q, output logic [2:0] fl, output int lat);
    logic s;
    longint unsigned sa, sb, num, qt, rem, m, low;
    int ea, eb, p, e, g;
    logic [15:0] ev;
    logic sticky;
    s  = ma_in[15] ^ mb_in[15];
    fl = 3'b000;
    if (mb_in[14:0] == 15'd0) begin
      q = {s, 5'h1F, 10'h000}; fl = 3'b001; lat = 1;
    end else if (ma_in[14:0] == 15'd0) begin
      q = {s, 15'd0}; lat = 1;
    end else begin
      sa  = (ma_in[14:10] != 0) ? (64'd1024 + ma_in[9:0]) : ma_in[9:0];
      sb  = (mb_in[14:10] != 0) ? (64'd1024 + mb_in[9:0]) : mb_in[9:0];
      ea  = (ma_in[14:10] != 0) ? int'(ma_in[14:10]) : 1;
      eb  = (mb_in[14:10] != 0) ? int'(mb_in[14:10]) : 1;
      num = sa << 40;
      qt  = num / sb;
      rem = num % sb;
      p = 0;
      for (int i = 63; i >= 0; i--) begin
        if (((qt >> i) & 1) != 0) begin p = i; break; end
      end
      e      = p + ea - eb - 40 + 15;
      m      = qt >> (p - 10);
      g      = int'((qt >> (p - 11)) & 1);
      low    = qt & ((64'd1 << (p - 11)) - 1);
      sticky = (low != 0) || (rem != 0);
      if (g == 1 && (sticky || (m & 1) == 1)) m++;
      if (m == 2048) begin m = 1024; e++; end
      if (e >= 31) begin
        q = {s, 5'h1F, 10'h000}; fl = 3'b100;
      end else if (e <= 0) begin
        q = {s, 15'd0}; fl = 3'b010;
      end else begin
        ev = 16'(e);
        q  = {s, ev[4:0], m[9:0]};
      end
      lat = 17 + ((lz11(sa) > lz11(sb)) ? lz11(sa) : lz11(sb));
    end
  endtask

  // Issue one request and wait (bounded) for done; leaves the DUT back in IDLE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        output logic [15:0] q, output logic [2:0] fl, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    fl = {ovf, unf, dbz};
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] q, eq;
    logic [2:0]  fl, efl;
    int          lat, elat, npulse, nbusy;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 17};
    vecs[1] = '{16'h4600, 16'h4000, 16'h4200, 3'b000, 17};
    vecs[2] = '{16'h3C00, 16'h4200, 16'h3555, 3'b000, 17};
    vecs[3] = '{16'h0200, 16'h3800, 16'h0400, 3'b000, 18};
    vecs[4] = '{16'h7BFF, 16'h0400, 16'h7C00, 3'b100, 17};
    vecs[5] = '{16'h0400, 16'h7800, 16'h0000, 3'b010, 17};
    vecs[6] = '{16'h3C00, 16'h8000, 16'hFC00, 3'b001, 1};
    vecs[7] = '{16'h0000, 16'h0000, 16'h7C00, 3'b001, 1};

    rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
    #12;
    chk("reset_quotient", {16'd0, quotient}, 32'd0);
    chk("reset_flags", {29'd0, ovf, unf, dbz}, 32'd0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, fl, lat);
      chk($sformatf("vec%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
      chk($sformatf("vec%0d_flags", i), {29'd0, fl}, {29'd0, vecs[i].fl});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Operands change after acceptance; result must reflect the latched values.
    @(negedge clk);
    a = 16'h4600; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h3C00; b = 16'h4200;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("latched_operands_q", {16'd0, quotient}, 32'h4200);
    chk("latched_operands_lat", lat, 17);
    @(posedge clk); #1;

    // Reset pulsed in the middle of DIV aborts with no result written.
    @(negedge clk);
    a = 16'h3C00; b = 16'h4200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_div", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    #5;
    rst_n = 1'b1;
    npulse = 0; nbusy = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) npulse++;
      if (busy) nbusy++;
    end
    chk("abort_no_done", npulse, 0);
    chk("abort_idle", nbusy, 0);

    // Start held high through the whole operation: one done pulse only.
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; start = 1'b1;
    npulse = 0; lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    if (done) npulse++;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    chk("held_start_pulses", npulse, 1);
    chk("held_start_q", {16'd0, quotient}, 32'h3C00);

    // Random operands, subnormals and zeros mixed in.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra[14:10] = 5'd0;
      if ($urandom_range(0, 3) == 0) rb[14:10] = 5'd0;
      if ($urandom_range(0, 19) == 0) ra[14:0] = 15'd0;
      if ($urandom_range(0, 19) == 0) rb[14:0] = 15'd0;
      model(ra, rb, eq, efl, elat);
      run_op(ra, rb, q, fl, lat);
      chk($sformatf("rnd%0d_q %h/%h", i, ra, rb), {16'd0, q}, {16'd0, eq});
      chk($sformatf("rnd%0d_flags %h/%h", i, ra, rb), {29'd0, fl}, {29'd0, efl});
      chk($sformatf("rnd%0d_lat %h/%h", i, ra, rb), lat, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
